cla_adder_pipe: RTL and testbench
=================================

Name: cla_adder_pipe

Overview:
- Parametrised, two-stage pipelined carry-lookahead adder/subtractor for the ALU datapath.
- Successor to the fixed 4-bit lookahead unit. It generalises width to any multiple of 4 and adds subtract mode, status flags and a valid/ready pipeline with backpressure.
- Sits between operand select and the ALU result mux.

Parameters:
WIDTH, 32, operand width in bits; must be a multiple of 4, range 4..64 (checked at elaboration).
GROUP, 4, bits per first-level lookahead group; fixed at 4, and any other value is an elaboration error.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
in_valid  input  1  operand beat valid
in_ready  output  1  block accepts a beat this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
sub  input  1  0 = A+B+cin, 1 = A+~B+1 (cin ignored)
cin  input  1  carry in (add mode only)
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
sum  output  WIDTH  result
cout  output  1  carry out of MSB (in sub mode 1 = no borrow)
ovf  output  1  signed overflow
zero  output  1  sum == 0

Behaviour:
- Reset (rst=1 at posedge):
  - s1_v, s2_v cleared; out_valid=0.
  - sum, cout, ovf, zero all 0.
  - Data registers cleared; rst has priority over every other event.
- Operand prep (combinational, pre-stage 1):
  - bx = sub ? ~b : b; c0 = sub ? 1 : cin.
  - Per bit: g = a & bx, p = a ^ bx.
- Stage 1 register, captured on accept:
  - Captures p[WIDTH-1:0], g[WIDTH-1:0] and c0.
  - Captures per-group G_k, P_k for k = 0..WIDTH/4-1, using standard 4-bit lookahead: G = g3|p3g2|p3p2g1|p3p2p1g0, P = p3p2p1p0.
  - Captures a[MSB], bx[MSB] for overflow.
- Stage 2 (combinational from stage-1 regs, registered into outputs):
  - Group carries C_k by second-level lookahead over G/P: C_0 = c0, C_{k+1} = G_k | P_k C_k, realised as 4-group lookahead blocks cascaded.
  - In-group carries from C_k via the 4-bit lookahead equations.
  - sum_i = p_i ^ c_i; cout = carry out of the MSB group.
  - ovf = (a_msb == bx_msb) & (sum_msb != a_msb); zero = ~|sum.
- Latency: an accepted beat appears on outputs 2 cycles later if not stalled. Throughput is 1 beat/cycle.
- Handshake:
  - s2_adv = ~s2_v | out_ready; s1_adv = ~s1_v | s2_adv; in_ready = s1_adv, combinational from out_ready.
  - Input is accepted when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready; out_valid = s2_v.
  - On s2_adv: s2_v <= s1_v and output regs load from stage 1 (only if s1_v). On s1_adv: s1_v <= accept.
  - While out_valid & ~out_ready: sum/cout/ovf/zero held stable; no data lost or reordered.
  - At most 2 beats buffered. With out_ready=0 and both stages full, in_ready=0.
  - Simultaneous output transfer and input accept with both stages full is allowed; the pipeline shifts by one.
- Bubbles collapse: s1_v=0 never blocks input.
- Boundaries:
  - WIDTH=4 collapses to one group; the stage-2 group network is C_0 only.
  - Mid-operation reset discards all in-flight beats.
  - in_valid=0 inputs are ignored; X on a/b while in_valid=0 must not propagate to outputs.

Test Plan:
1. WIDTH=32, rst 2 cycles, then a=FFFFFFFF, b=00000001, sub=0, cin=0, out_ready=1 -> 2 cycles later out_valid=1, sum=00000000, cout=1, zero=1, ovf=0.
2. Subtract a=5, b=7, sub=1 -> sum=FFFFFFFE, cout=0, ovf=0, zero=0. Then a=80000000, b=1, sub=1 -> sum=7FFFFFFF, ovf=1, cout=1.
3. Overflow/carry-in: a=7FFFFFFF, b=0, cin=1 -> sum=80000000, ovf=1, cout=0. Full carry ripple a=FFFFFFFF, b=0, cin=1 -> sum=0, cout=1.
4. Backpressure:
   - out_ready=0, present beats 1+1, 2+2, 3+3 back-to-back -> in_ready drops after 2 accepts, output holds 2.
   - Raise out_ready -> outputs 2, 4, 6 in order, one per cycle, none lost.
5. Streaming: 100 random beats with random in_valid/out_ready -> all results match reference model, in order; full-speed segments sustain 1 result/cycle.
6. Reset mid-stream: assert rst with both stages valid -> next cycle out_valid=0, sum=0, in_ready=1; a subsequent beat 3+4 gives sum=7 after 2 cycles. Repeat test 1 pattern at WIDTH=4 and WIDTH=64.

Source files
------------

// File: rtl/cla_adder_pipe.sv
// rtl/cla_adder_pipe.sv - two-stage pipelined carry-lookahead adder/subtractor with valid/ready
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   in_valid/ready  operand beat handshake (a, b, sub, cin)
//   out_valid/ready result handshake (sum, cout, ovf, zero)
//   sub=1 computes a + ~b + 1 and ignores cin; cout=1 then means "no borrow"
module cla_adder_pipe #(
    parameter int WIDTH = 32,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NG = WIDTH / 4;        // first-level groups
    localparam int NB = (NG + 3) / 4;     // second-level blocks of 4 groups

    generate
        if (GROUP != 4) begin : g_bad_group
            $error("cla_adder_pipe: GROUP must be 4");
        end
        if ((WIDTH % 4) != 0 || WIDTH < 4 || WIDTH > 64) begin : g_bad_width
            $error("cla_adder_pipe: WIDTH must be a multiple of 4 in 4..64");
        end
    endgenerate

    // Carries c1..c4 of a 4-wide lookahead cell, fully flattened (no ripple).
    function automatic logic [4:1] la4(input logic [3:0] g, input logic [3:0] p, input logic c);
        logic [4:1] r;
        r[1] = g[0] | (p[0] & c);
        r[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
        r[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
        r[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c);
        return r;
    endfunction

    // In-group carries c1..c3; the group's carry out comes from the group network.
    function automatic logic [3:1] la3(input logic [2:0] g, input logic [2:0] p, input logic c);
        logic [3:1] r;
        r[1] = g[0] | (p[0] & c);
        r[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
        r[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
        return r;
    endfunction

    // Operand prep and first-level group generate/propagate
    logic [WIDTH-1:0] bx, g, p;
    logic             c0;
    logic [NG-1:0]    grp_g, grp_p;

    always_comb begin
        bx    = sub ? ~b : b;
        c0    = sub ? 1'b1 : cin;
        g     = a & bx;
        p     = a ^ bx;
        grp_g = '0;
        grp_p = '0;
        for (int k = 0; k < NG; k++) begin
            grp_g[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            grp_p[k] = &p[4*k +: 4];
        end
    end

    // Pipeline control
    logic s1_v, s2_v, s1_adv, s2_adv, accept;

    assign s2_adv    = ~s2_v | out_ready;
    assign s1_adv    = ~s1_v | s2_adv;
    assign in_ready  = s1_adv;
    assign accept    = in_valid & in_ready;
    assign out_valid = s2_v;

    // Stage 1 registers
    logic [WIDTH-1:0] s1_p, s1_g;
    logic [NG-1:0]    s1_gg, s1_gp;
    logic             s1_c0, s1_amsb, s1_bmsb;

    // Stage 2 combinational carry network
    logic [NB*4-1:0]  gg_pad, gp_pad;
    logic [NB*4:0]    gc;
    logic [WIDTH-1:0] cv, sum_n;
    logic             cout_n, ovf_n, zero_n;

    always_comb begin
        gg_pad = '0;
        gp_pad = '0;
        gg_pad[NG-1:0] = s1_gg;
        gp_pad[NG-1:0] = s1_gp;
        // Second level: 4-group lookahead blocks, cascaded block to block.
        // Padding groups have G=P=0, so carries beyond group NG are don't-care.
        gc    = '0;
        gc[0] = s1_c0;
        for (int blk = 0; blk < NB; blk++) begin
            gc[4*blk+1 +: 4] = la4(gg_pad[4*blk +: 4], gp_pad[4*blk +: 4], gc[4*blk]);
        end
        cv = '0;
        for (int k = 0; k < NG; k++) begin
            cv[4*k]       = gc[k];
            cv[4*k+1 +: 3] = la3(s1_g[4*k +: 3], s1_p[4*k +: 3], gc[k]);
        end
        sum_n  = s1_p ^ cv;
        cout_n = gc[NG];
        ovf_n  = (s1_amsb == s1_bmsb) & (sum_n[WIDTH-1] != s1_amsb);
        zero_n = ~|sum_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v    <= 1'b0;
            s2_v    <= 1'b0;
            s1_p    <= '0;
            s1_g    <= '0;
            s1_gg   <= '0;
            s1_gp   <= '0;
            s1_c0   <= 1'b0;
            s1_amsb <= 1'b0;
            s1_bmsb <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
            zero    <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_v <= accept;
            end
            // Data captured only on accept so idle-cycle operands never enter the pipe.
            if (accept) begin
                s1_p    <= p;
                s1_g    <= g;
                s1_gg   <= grp_g;
                s1_gp   <= grp_p;
                s1_c0   <= c0;
                s1_amsb <= a[WIDTH-1];
                s1_bmsb <= bx[WIDTH-1];
            end
            if (s2_adv) begin
                s2_v <= s1_v;
                if (s1_v) begin
                    sum  <= sum_n;
                    cout <= cout_n;
                    ovf  <= ovf_n;
                    zero <= zero_n;
                end
            end
        end
    end

endmodule

// File: tb/tb_cla_adder_pipe.sv
// tb/tb_cla_adder_pipe.sv - self-checking bench for cla_adder_pipe (WIDTH 32, 4, 64)
module tb_cla_adder_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // WIDTH=32 instance
    logic        in_valid, in_ready, sub, cin, out_valid, out_ready, cout, ovf, zero;
    logic [31:0] a, b, sum;
    // WIDTH=4 instance
    logic        in_valid_4, in_ready_4, out_valid_4, cout_4, ovf_4, zero_4;
    logic [3:0]  a_4, b_4, sum_4;
    // WIDTH=64 instance
    logic        in_valid_64, in_ready_64, out_valid_64, cout_64, ovf_64, zero_64;
    logic [63:0] a_64, b_64, sum_64;

    cla_adder_pipe #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .sub(sub), .cin(cin), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
        .cout(cout), .ovf(ovf), .zero(zero));

    cla_adder_pipe #(.WIDTH(4)) dut_4 (
        .clk(clk), .rst(rst), .in_valid(in_valid_4), .in_ready(in_ready_4), .a(a_4), .b(b_4),
        .sub(1'b0), .cin(1'b0), .out_valid(out_valid_4), .out_ready(1'b1), .sum(sum_4),
        .cout(cout_4), .ovf(ovf_4), .zero(zero_4));

    cla_adder_pipe #(.WIDTH(64)) dut_64 (
        .clk(clk), .rst(rst), .in_valid(in_valid_64), .in_ready(in_ready_64), .a(a_64), .b(b_64),
        .sub(1'b0), .cin(1'b0), .out_valid(out_valid_64), .out_ready(1'b1), .sum(sum_64),
        .cout(cout_64), .ovf(ovf_64), .zero(zero_64));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] a, b;
        logic        sub, cin;
        logic [31:0] sum;
        logic        cout, ovf, zero;
    } vec_t;

    // Reference model: plain integer arithmetic; returns {cout, ovf, zero, sum}
    function automatic logic [34:0] ref_model(input logic [31:0] x, input logic [31:0] y,
                                             input logic s, input logic ci);
        logic [32:0] u;
        longint      sv;
        logic        co, ov;
        if (s) begin
            u  = {1'b0, x - y};
            co = (x >= y);
            sv = longint'($signed(x)) - longint'($signed(y));
        end else begin
            u  = {1'b0, x} + {1'b0, y} + {32'd0, ci};
            co = u[32];
            sv = longint'($signed(x)) + longint'($signed(y)) + longint'(ci);
        end
        ov = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
        return {co, ov, (u[31:0] == 32'd0), u[31:0]};
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic drive(input logic iv, input logic [31:0] x, input logic [31:0] y,
                         input logic s, input logic ci, input logic ordy);
        @(negedge clk);
        in_valid = iv; a = x; b = y; sub = s; cin = ci; out_ready = ordy;
        #1;
    endtask

    // Single beat through an empty pipe; checks 2-cycle latency and result fields.
    task automatic run_vec(input string name, input vec_t v);
        int lat = 1;
        drive(1'b1, v.a, v.b, v.sub, v.cin, 1'b1);
        chk({name, "_in_ready"}, in_ready, 1);
        drive(1'b0, $urandom, $urandom, $urandom, $urandom, 1'b1);
        while (!out_valid && lat < 6) begin
            drive(1'b0, $urandom, $urandom, 1'b0, 1'b0, 1'b1);
            lat++;
        end
        chk({name, "_latency"}, lat, 2);
        chk({name, "_result"}, {cout, ovf, zero, sum}, {v.cout, v.ovf, v.zero, v.sum});
    endtask

    vec_t tbl[7];
    logic [34:0] q[$];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        in_valid = 0; a = 0; b = 0; sub = 0; cin = 0; out_ready = 1;
        in_valid_4 = 0; a_4 = 0; b_4 = 0; in_valid_64 = 0; a_64 = 0; b_64 = 0;

        tbl[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        tbl[1] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{32'h7FFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        tbl[5] = '{32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0007, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{32'h0000_0007, 32'h0000_0007, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};

        // Reset for two cycles
        rst = 1;
        @(negedge clk);
        @(negedge clk);
        chk("reset_state", {out_valid, cout, ovf, zero, sum}, 36'h0);
        chk("reset_in_ready", in_ready, 1);
        rst = 0;

        // Table-driven vectors
        for (int i = 0; i < 7; i++) begin
            run_vec($sformatf("vec%0d", i), tbl[i]);
        end

        // Backpressure: fill both stages, hold, then drain in order
        drive(1'b1, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0);
        chk("bp_accept1", in_ready, 1);
        drive(1'b1, 32'd2, 32'd2, 1'b0, 1'b0, 1'b0);
        chk("bp_accept2", in_ready, 1);
        drive(1'b1, 32'd3, 32'd3, 1'b0, 1'b0, 1'b0);
        chk("bp_full_in_ready", in_ready, 0);
        chk("bp_hold_a", {out_valid, sum}, {1'b1, 32'd2});
        drive(1'b1, 32'd3, 32'd3, 1'b0, 1'b0, 1'b0);
        chk("bp_hold_b", {out_valid, in_ready, sum}, {1'b1, 1'b0, 32'd2});
        drive(1'b1, 32'd3, 32'd3, 1'b0, 1'b0, 1'b1);
        chk("bp_shift_in_ready", in_ready, 1);
        chk("bp_out2", {out_valid, sum}, {1'b1, 32'd2});
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        chk("bp_out4", {out_valid, sum}, {1'b1, 32'd4});
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        chk("bp_out6", {out_valid, sum}, {1'b1, 32'd6});
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        chk("bp_empty", out_valid, 0);

        // Random streaming against the reference model
        begin
            int sent = 0, recv = 0, cyc = 0;
            logic [34:0] e;
            while ((sent < 100 || recv < sent) && cyc < 3000) begin
                drive((sent < 100) && ($urandom_range(0, 9) < 7), pick(), pick(),
                      $urandom, $urandom, $urandom_range(0, 9) < 7);
                cyc++;
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        chk("stream_spurious", 1, 0);
                    end else begin
                        e = q.pop_front();
                        chk($sformatf("stream_beat%0d", recv), {cout, ovf, zero, sum}, e);
                        recv++;
                    end
                end
                if (in_valid && in_ready) begin
                    q.push_back(ref_model(a, b, sub, cin));
                    sent++;
                end
            end
            chk("stream_count", recv, 100);
        end

        // Full-speed segment: one result per cycle once the pipe is primed
        begin
            int xfers = 0, stalls = 0;
            logic [34:0] e;
            q.delete();
            for (int c = 0; c < 22; c++) begin
                drive(c < 20, pick(), pick(), $urandom, $urandom, 1'b1);
                if (c < 20 && !in_ready) stalls++;
                if (out_valid) begin
                    if (q.size() > 0) begin
                        e = q.pop_front();
                        chk($sformatf("full_beat%0d", xfers), {cout, ovf, zero, sum}, e);
                    end
                    xfers++;
                end
                if (in_valid && in_ready) q.push_back(ref_model(a, b, sub, cin));
            end
            chk("full_speed_xfers", xfers, 20);
            chk("full_speed_stalls", stalls, 0);
        end

        // Reset with both stages valid
        drive(1'b1, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'd2, 32'd2, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("prereset_full", {out_valid, in_ready}, 2'b10);
        rst = 1;
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        chk("midreset_state", {out_valid, sum, in_ready}, {1'b0, 32'd0, 1'b1});
        rst = 0;
        run_vec("post_reset", '{32'd3, 32'd4, 1'b0, 1'b0, 32'd7, 1'b0, 1'b0, 1'b0});
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        chk("post_reset_drained", out_valid, 0);

        // WIDTH=4 and WIDTH=64: all-ones + 1
        @(negedge clk);
        in_valid_4 = 1; a_4 = 4'hF; b_4 = 4'h1;
        in_valid_64 = 1; a_64 = '1; b_64 = 64'd1;
        #1;
        chk("w4_in_ready", in_ready_4, 1);
        chk("w64_in_ready", in_ready_64, 1);
        @(negedge clk);
        in_valid_4 = 0; a_4 = 4'h5; b_4 = 4'h6;
        in_valid_64 = 0; a_64 = 64'h1234; b_64 = 64'h5678;
        chk("w4_lat1", out_valid_4, 0);
        chk("w64_lat1", out_valid_64, 0);
        @(negedge clk);
        chk("w4_result", {out_valid_4, cout_4, ovf_4, zero_4, sum_4}, {4'b1101, 4'h0});
        chk("w64_result", {out_valid_64, cout_64, ovf_64, zero_64, sum_64}, {4'b1101, 64'h0});
        @(negedge clk);
        chk("w4_idle", out_valid_4, 0);
        chk("w64_idle", out_valid_64, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
